// File: rtl/truth_table_scanner_pkg.sv
// Shared definitions for the truth-table scanner: FSM encoding, default sizes
// and the golden tables of the fxyz function set (bit i = output at {x,y,z}==i).
package truth_table_scanner_pkg;

  localparam int N_FUNCS_DEF = 5;
  localparam int N_IN_DEF    = 3;
  localparam int TT_DEF      = 1 << N_IN_DEF;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DRIVE  = 3'd1,
    S_WAIT   = 3'd2,
    S_SAMPLE = 3'd3,
    S_CHECK  = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  localparam logic [TT_DEF-1:0] FXYZ_A = 8'h04;
  localparam logic [TT_DEF-1:0] FXYZ_B = 8'h80;
  localparam logic [TT_DEF-1:0] FXYZ_C = 8'h45;
  localparam logic [TT_DEF-1:0] FXYZ_D = 8'hA2;
  localparam logic [TT_DEF-1:0] FXYZ_E = 8'hCD;

  localparam logic [N_FUNCS_DEF*TT_DEF-1:0] FXYZ_GOLDEN =
    {FXYZ_E, FXYZ_D, FXYZ_C, FXYZ_B, FXYZ_A};

endpackage

// File: rtl/truth_table_scanner_tt_sequencer.sv
// Input-combination sequencer: walks idx 0..TT-1, drives the xyz bus and times
// the settle interval before each sample.
module tt_sequencer #(
  parameter int N_IN   = 3,
  parameter int SETTLE = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clear,
  input  logic            drive,
  input  logic            wait_en,
  input  logic            advance,
  output logic [N_IN-1:0] xyz,
  output logic            sample_go,
  output logic            last
);

  localparam int TT = 1 << N_IN;
  localparam int CW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;

  // One extra bit keeps the terminal compare free of wrap-around.
  logic [N_IN:0]   idx;
  logic [CW-1:0]   cnt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its neighbours, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx <= '0;
      cnt <= '0;
      xyz <= '0;
    end else begin
      if (clear)        idx <= '0;
      else if (advance) idx <= idx + (N_IN+1)'(1);

      if (drive) begin
        xyz <= idx[N_IN-1:0];
        cnt <= CW'(SETTLE);
      end else if (wait_en) begin
        cnt <= cnt - CW'(1);
      end
    end
  end

  // Asserted on the WAIT cycle whose decrement brings the counter to zero.
  assign sample_go = (SETTLE == 0) || (cnt == CW'(1));
  assign last      = (idx == (N_IN+1)'(TT - 1));

endmodule

// File: rtl/truth_table_scanner.sv
// Self-checking scanner around a combinational function set: sweeps {x,y,z},
// captures one truth table per function and compares it with a golden table.
module truth_table_scanner
  import truth_table_scanner_pkg::*;
#(
  parameter int N_FUNCS = N_FUNCS_DEF,
  parameter int N_IN    = N_IN_DEF,
  parameter int SETTLE  = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [N_FUNCS*(1<<N_IN)-1:0] expected,
  input  logic [N_FUNCS-1:0]           s_in,
  output logic [N_IN-1:0]              xyz,
  output logic                         busy,
  output logic                         done,
  output logic [N_FUNCS*(1<<N_IN)-1:0] table_out,
  output logic [N_FUNCS-1:0]           mismatch,
  output logic                         pass
);

  localparam int TT = 1 << N_IN;

  state_t state, state_next;
  logic   sample_go, last;

  logic [N_FUNCS-1:0][TT-1:0] tables;
  logic [N_FUNCS-1:0][TT-1:0] exp_tables;
  logic [N_FUNCS-1:0]         mis_vec;

  tt_sequencer #(
    .N_IN   (N_IN),
    .SETTLE (SETTLE)
  ) u_seq (
    .clk       (clk),
    .reset     (reset),
    .clear     (state == S_IDLE && start),
    .drive     (state == S_DRIVE),
    .wait_en   (state == S_WAIT),
    .advance   (state == S_SAMPLE && !last),
    .xyz       (xyz),
    .sample_go (sample_go),
    .last      (last)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // NOTE: next state gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (start) state_next = S_DRIVE;
      S_DRIVE:  state_next = (SETTLE == 0) ? S_SAMPLE : S_WAIT;
      S_WAIT:   if (sample_go) state_next = S_SAMPLE;
      S_SAMPLE: state_next = last ? S_CHECK : S_DRIVE;
      S_CHECK:  state_next = S_DONE;
      S_DONE:   state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  assign done       = (state == S_DONE);
  assign exp_tables = expected;
  assign table_out  = tables;

  // Case inequality so an unknown captured bit is reported as a mismatch.
  always_comb begin
    mis_vec = '0;
    for (int f = 0; f < N_FUNCS; f++)
      mis_vec[f] = (tables[f] !== exp_tables[f]);
  end

  // NOTE: the capture tables are reset explicitly because a mid-scan reset
  // must discard any partial table visible on table_out.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy     <= 1'b0;
      tables   <= '0;
      mismatch <= '0;
      pass     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          busy   <= 1'b1;
          tables <= '0;
        end
        S_SAMPLE: for (int f = 0; f < N_FUNCS; f++) tables[f][xyz] <= s_in[f];
        S_CHECK: begin
          mismatch <= mis_vec;
          pass     <= ~|mis_vec;
        end
        S_DONE:  busy <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule
